// File: rtl/cache_axi_master.sv
// cache_axi_master: runs one cache-line refill or writeback as a single AXI4 INCR burst.
// Optional build macro CACHE_AXI_MASTER_TIMEOUT_EN adds a debug watchdog.
// The watchdog abandons any AXI phase that has stalled for 255 cycles and reports an error.
module cache_axi_master #(
   parameter int         LINE_BEATS = 2,
   parameter logic [3:0] AXI_ID     = 4'd0
) (
   input  logic                      clock,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [31:0]               req_addr,
   input  logic [64*LINE_BEATS-1:0]  req_wline,
   output logic                      resp_valid,
   output logic [64*LINE_BEATS-1:0]  resp_rline,
   output logic                      resp_err,
   output logic                      arvalid,
   input  logic                      arready,
   output logic [3:0]                arid,
   output logic [31:0]               araddr,
   output logic [7:0]                arlen,
   output logic [2:0]                arsize,
   output logic [1:0]                arburst,
   input  logic                      rvalid,
   output logic                      rready,
   input  logic [3:0]                rid,
   input  logic [63:0]               rdata,
   input  logic [1:0]                rresp,
   input  logic                      rlast,
   output logic                      awvalid,
   input  logic                      awready,
   output logic [3:0]                awid,
   output logic [31:0]               awaddr,
   output logic [7:0]                awlen,
   output logic [2:0]                awsize,
   output logic [1:0]                awburst,
   output logic                      wvalid,
   input  logic                      wready,
   output logic [63:0]               wdata,
   output logic [7:0]                wstrb,
   output logic                      wlast,
   input  logic                      bvalid,
   output logic                      bready,
   input  logic [3:0]                bid,
   input  logic [1:0]                bresp
);

   localparam int            LW        = 64 * LINE_BEATS;
   localparam int            CW        = $clog2(LINE_BEATS) + 1;
   localparam int            OFS       = $clog2(8 * LINE_BEATS);
   localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_BEATS - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_AR,
      S_R,
      S_AW,
      S_W,
      S_B,
      S_RESP
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [CW-1:0] cnt_q;
   logic          err_q;
   logic [31:0]   addr_q;
   logic [LW-1:0] line_q;
   logic          last_beat;
   logic          addr_low_unused;

   // The line offset bits of the request address never reach the bus.
   assign addr_low_unused = ^req_addr[OFS-1:0];
   assign last_beat       = (cnt_q == LAST_BEAT);

   assign arid    = AXI_ID;
   assign awid    = AXI_ID;
   assign araddr  = addr_q;
   assign awaddr  = addr_q;
   assign arlen   = 8'(LINE_BEATS - 1);
   assign awlen   = 8'(LINE_BEATS - 1);
   assign arsize  = 3'b011;
   assign awsize  = 3'b011;
   assign arburst = 2'b01;
   assign awburst = 2'b01;
   assign wstrb   = 8'hFF;

   assign resp_rline = line_q;
   assign resp_err   = err_q;

`ifdef CACHE_AXI_MASTER_TIMEOUT_EN
   logic [7:0] wd_q;
   logic       busy;
   logic       handshake;
   logic       wd_fire;

   assign busy      = (state_q == S_AR) || (state_q == S_R) || (state_q == S_AW) ||
                      (state_q == S_W)  || (state_q == S_B);
   assign handshake = ((state_q == S_AR) && arready) || ((state_q == S_R) && rvalid) ||
                      ((state_q == S_AW) && awready) || ((state_q == S_W) && wready) ||
                      ((state_q == S_B) && bvalid);
   // Fires on the stalled cycle that would bring the stall count to 255.
   assign wd_fire   = busy && !handshake && (wd_q == 8'd254);

   // Stall counter: restarts on every handshake and whenever the block is idle.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         wd_q <= 8'd0;
      end else if (busy && !handshake) begin
         wd_q <= wd_q + 8'd1;
      end else begin
         wd_q <= 8'd0;
      end
   end
`endif

   // State register; reset drops every valid at once because they decode from state.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and the handshake outputs decoded from the current state.
   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      arvalid    = 1'b0;
      rready     = 1'b0;
      awvalid    = 1'b0;
      wvalid     = 1'b0;
      wlast      = 1'b0;
      bready     = 1'b0;
      resp_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = req_write ? S_AW : S_AR;
         end
         S_AR: begin
            arvalid = 1'b1;
            if (arready) state_d = S_R;
         end
         S_R: begin
            rready = 1'b1;
            if (rvalid && last_beat) state_d = S_RESP;
         end
         S_AW: begin
            awvalid = 1'b1;
            if (awready) state_d = S_W;
         end
         S_W: begin
            wvalid = 1'b1;
            wlast  = last_beat;
            if (wready && last_beat) state_d = S_B;
         end
         S_B: begin
            bready = 1'b1;
            if (bvalid) state_d = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
`ifdef CACHE_AXI_MASTER_TIMEOUT_EN
      if (wd_fire) state_d = S_RESP;
`endif
   end

   // Write data mux: the line slot selected by the beat counter.
   always_comb begin
      wdata = '0;
      for (int i = 0; i < LINE_BEATS; i++) begin
         if (cnt_q == CW'(i)) wdata = line_q[i*64 +: 64];
      end
   end

   // Request latch, beat counter, line buffer and sticky per-transaction error flag.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         err_q  <= 1'b0;
         addr_q <= '0;
         line_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  addr_q <= {req_addr[31:OFS], {OFS{1'b0}}};
                  line_q <= req_wline;
                  cnt_q  <= '0;
                  err_q  <= 1'b0;
               end
            end
            S_R: begin
               if (rvalid) begin
                  for (int i = 0; i < LINE_BEATS; i++) begin
                     if (cnt_q == CW'(i)) line_q[i*64 +: 64] <= rdata;
                  end
                  cnt_q <= cnt_q + CNT_ONE;
                  if ((rresp != 2'b00) || (rid != AXI_ID) || (rlast != last_beat)) err_q <= 1'b1;
               end
            end
            S_W: begin
               if (wready) cnt_q <= cnt_q + CNT_ONE;
            end
            S_B: begin
               if (bvalid && ((bresp != 2'b00) || (bid != AXI_ID))) err_q <= 1'b1;
            end
            default: begin
            end
         endcase
`ifdef CACHE_AXI_MASTER_TIMEOUT_EN
         if (wd_fire) err_q <= 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_cache_axi_master.sv
// tb_cache_axi_master: directed refill/writeback vectors against a reactive AXI slave,
// with responses checked by a scoreboard monitor and W beats by an expected-beat queue.
module tb_cache_axi_master;

   localparam int LB = 2;
   localparam int LW = 64 * LB;

   typedef struct {
      logic [LW-1:0] line;
      logic          err;
      bit            chk_line;
      int            lat;
      int            req_cyc;
   } exp_t;

   typedef struct {
      logic [63:0] data;
      logic        last;
   } wexp_t;

   logic          clock = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready, req_write;
   logic [31:0]   req_addr;
   logic [LW-1:0] req_wline, resp_rline;
   logic          resp_valid, resp_err;
   logic          arvalid, arready;
   logic [3:0]    arid;
   logic [31:0]   araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic          rvalid, rready, rlast;
   logic [3:0]    rid;
   logic [63:0]   rdata;
   logic [1:0]    rresp;
   logic          awvalid, awready;
   logic [3:0]    awid;
   logic [31:0]   awaddr;
   logic [7:0]    awlen;
   logic [2:0]    awsize;
   logic [1:0]    awburst;
   logic          wvalid, wready, wlast;
   logic [63:0]   wdata;
   logic [7:0]    wstrb;
   logic          bvalid, bready;
   logic [3:0]    bid;
   logic [1:0]    bresp;

   int            checks = 0;
   int            fails = 0;
   int            cyc = 0;
   exp_t          sb[$];
   wexp_t         wq[$];
   bit            resp_seen = 0;

   logic [63:0]   rd_data [LB];
   logic [1:0]    rd_resp [LB];
   logic          rlast_flip [LB];
   logic [3:0]    rd_id, b_id;
   logic [1:0]    b_resp;
   logic [31:0]   exp_addr;
   int            ar_wait, aw_wait, w_wait, r_wait;
   int            ar_cnt, aw_cnt, w_cnt, r_cnt;
   int            rbeat, ar_hs;
   bit            aw_done;

   cache_axi_master #(.LINE_BEATS(LB), .AXI_ID(4'd0)) dut (
      .clock(clock), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wline(req_wline),
      .resp_valid(resp_valid), .resp_rline(resp_rline), .resp_err(resp_err),
      .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
      .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
      .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
   );

   // 100 MHz clock.
   always #5 clock = ~clock;

   // Free-running cycle count used for latency measurement.
   always @(posedge clock) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic setSlaveDefaults();
      for (int i = 0; i < LB; i++) begin
         rd_data[i]    = 64'h0;
         rd_resp[i]    = 2'b00;
         rlast_flip[i] = 1'b0;
      end
      rd_id   = 4'd0;
      b_id    = 4'd0;
      b_resp  = 2'b00;
      ar_wait = 0;
      aw_wait = 0;
      w_wait  = 0;
      r_wait  = 0;
   endtask

   // Present a request, wait for acceptance and queue the response it should produce.
   task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [LW-1:0] wline,
                                input logic [LW-1:0] exp_line, input logic exp_err,
                                input bit chk_line, input int exp_lat, input bit expect_resp);
      int   n = 0;
      exp_t e;
      @(posedge clock);
      #1;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wline = wline;
      @(negedge clock);
      while (!req_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      checkOutput("req_accept", req_ready, 1);
      if (expect_resp) begin
         e.line     = exp_line;
         e.err      = exp_err;
         e.chk_line = chk_line;
         e.lat      = exp_lat;
         e.req_cyc  = cyc;
         sb.push_back(e);
      end
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 32'h0;
      req_wline = '0;
   endtask

   task automatic waitResp(input int limit);
      int n = 0;
      while (sb.size() != 0 && n < limit) begin
         @(negedge clock);
         n++;
      end
      checkOutput("resp_arrived", sb.size(), 0);
      sb.delete();
      @(negedge clock);
   endtask

   // Response monitor: pops the scoreboard on every completion pulse.
   always @(negedge clock) begin
      exp_t e;
      if (resp_seen) begin
         checkOutput("resp_one_cycle", resp_valid, 0);
         resp_seen = 0;
      end else if (rst_n && resp_valid) begin
         resp_seen = 1;
         if (sb.size() == 0) begin
            checkOutput("resp_unexpected", resp_valid, 0);
         end else begin
            e = sb.pop_front();
            checkOutput("resp_err", resp_err, e.err);
            if (e.chk_line) checkOutput("resp_rline", resp_rline, e.line);
            if (e.lat >= 0) checkOutput("resp_latency", cyc - e.req_cyc, e.lat);
         end
      end
   end

   // Reactive AXI slave: decides ready/valid for the current cycle from the DUT outputs.
   always @(negedge clock) begin
      if (!rst_n) begin
         arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
         rlast = 1'b0; rresp = 2'b00; rid = 4'd0; rdata = 64'h0; bresp = 2'b00; bid = 4'd0;
         ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; aw_done = 0;
      end else begin
         if (arvalid) begin
            if (ar_cnt >= ar_wait) begin
               arready = 1'b1;
               ar_hs++;
               ar_cnt = 0;
               rbeat  = 0;
               r_cnt  = 0;
               checkOutput("araddr", araddr, exp_addr);
               checkOutput("arlen", arlen, LB - 1);
               checkOutput("arsize", arsize, 3'b011);
               checkOutput("arburst", arburst, 2'b01);
               checkOutput("arid", arid, 4'd0);
            end else begin
               arready = 1'b0;
               ar_cnt++;
            end
         end else begin
            arready = 1'b0;
            ar_cnt  = 0;
         end

         if (rready) begin
            if (r_cnt < r_wait) begin
               rvalid = 1'b0;
               r_cnt++;
            end else begin
               rvalid = 1'b1;
               rid    = rd_id;
               if (rbeat < LB) begin
                  rdata = rd_data[rbeat];
                  rresp = rd_resp[rbeat];
                  rlast = (rbeat == LB - 1) ^ rlast_flip[rbeat];
               end else begin
                  rdata = 64'hDEAD_DEAD_DEAD_DEAD;
                  rresp = 2'b00;
                  rlast = 1'b1;
               end
               rbeat++;
            end
         end else begin
            rvalid = 1'b0;
         end

         if (wvalid) begin
            if (w_cnt >= w_wait) begin
               wexp_t w;
               wready = 1'b1;
               w_cnt  = 0;
               checkOutput("aw_before_w", aw_done, 1);
               checkOutput("wstrb", wstrb, 8'hFF);
               if (wq.size() == 0) begin
                  checkOutput("w_unexpected", wvalid, 0);
               end else begin
                  w = wq.pop_front();
                  checkOutput("wdata", wdata, w.data);
                  checkOutput("wlast", wlast, w.last);
               end
            end else begin
               wready = 1'b0;
               w_cnt++;
            end
         end else begin
            wready = 1'b0;
            w_cnt  = 0;
         end

         if (awvalid) begin
            if (aw_cnt >= aw_wait) begin
               awready = 1'b1;
               aw_cnt  = 0;
               aw_done = 1;
               checkOutput("awaddr", awaddr, exp_addr);
               checkOutput("awlen", awlen, LB - 1);
               checkOutput("awsize", awsize, 3'b011);
               checkOutput("awburst", awburst, 2'b01);
               checkOutput("awid", awid, 4'd0);
            end else begin
               awready = 1'b0;
               aw_cnt++;
            end
         end else begin
            awready = 1'b0;
            aw_cnt  = 0;
         end

         if (bready) begin
            bvalid  = 1'b1;
            bresp   = b_resp;
            bid     = b_id;
            aw_done = 0;
         end else begin
            bvalid = 1'b0;
         end
      end
   end

   // Overall time limit so a hung DUT still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish, %0d failures so far", fails);
      $fatal(1, "[TB] global timeout");
   end

   // Directed test sequence.
   initial begin
      int hs_before;
      rst_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wline = '0;
      arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      rlast = 1'b0; rresp = 2'b00; rid = 4'd0; rdata = 64'h0; bresp = 2'b00; bid = 4'd0;
      rbeat = 0; ar_hs = 0; exp_addr = 32'h0;
      setSlaveDefaults();

      repeat (3) @(negedge clock);
      checkOutput("rst_req_ready", req_ready, 1);
      checkOutput("rst_arvalid", arvalid, 0);
      checkOutput("rst_rready", rready, 0);
      checkOutput("rst_awvalid", awvalid, 0);
      checkOutput("rst_wvalid", wvalid, 0);
      checkOutput("rst_wlast", wlast, 0);
      checkOutput("rst_bready", bready, 0);
      checkOutput("rst_resp_valid", resp_valid, 0);
      checkOutput("rst_resp_err", resp_err, 0);
      checkOutput("rst_resp_rline", resp_rline, 0);
      rst_n = 1'b1;

      $display("[TB] refill, zero-wait slave");
      rd_data[0] = 64'h1111; rd_data[1] = 64'h2222;
      exp_addr = 32'h8000_0010;
      applyStimulus(0, 32'h8000_0018, '0, {64'h2222, 64'h1111}, 0, 1, 4, 1);
      waitResp(50);
      checkOutput("r_beats", rbeat, 2);

      $display("[TB] writeback, delayed awready/wready");
      aw_wait = 3; w_wait = 3;
      exp_addr = 32'h8000_0040;
      wq.push_back('{64'hAAAA, 1'b0});
      wq.push_back('{64'hBBBB, 1'b1});
      applyStimulus(1, 32'h8000_0040, {64'hBBBB, 64'hAAAA}, '0, 0, 0, -1, 1);
      waitResp(100);
      checkOutput("w_beats_left", wq.size(), 0);
      setSlaveDefaults();

      $display("[TB] refill, rresp error on beat 0");
      rd_data[0] = 64'h3333; rd_data[1] = 64'h4444; rd_resp[0] = 2'b10;
      exp_addr = 32'h8000_1000;
      applyStimulus(0, 32'h8000_1000, '0, {64'h4444, 64'h3333}, 1, 1, 4, 1);
      waitResp(50);
      checkOutput("r_beats_rresp", rbeat, 2);
      setSlaveDefaults();

      $display("[TB] writeback, zero-wait slave");
      exp_addr = 32'h0000_1230;
      wq.push_back('{64'h5555, 1'b0});
      wq.push_back('{64'h6666, 1'b1});
      applyStimulus(1, 32'h0000_1238, {64'h6666, 64'h5555}, '0, 0, 0, 5, 1);
      waitResp(50);
      checkOutput("w_beats_left2", wq.size(), 0);

      $display("[TB] refill, early rlast");
      rd_data[0] = 64'hA1; rd_data[1] = 64'hA2; rlast_flip[0] = 1'b1;
      exp_addr = 32'h8000_2020;
      applyStimulus(0, 32'h8000_2020, '0, {64'hA2, 64'hA1}, 1, 1, 4, 1);
      waitResp(50);
      checkOutput("r_beats_early", rbeat, 2);
      setSlaveDefaults();

      $display("[TB] refill, missing rlast");
      rd_data[0] = 64'hB1; rd_data[1] = 64'hB2; rlast_flip[1] = 1'b1;
      exp_addr = 32'h8000_2030;
      applyStimulus(0, 32'h8000_203F, '0, {64'hB2, 64'hB1}, 1, 1, 4, 1);
      waitResp(50);
      setSlaveDefaults();

      $display("[TB] refill, wrong rid");
      rd_data[0] = 64'hC1; rd_data[1] = 64'hC2; rd_id = 4'd3;
      exp_addr = 32'h8000_0100;
      applyStimulus(0, 32'h8000_0100, '0, {64'hC2, 64'hC1}, 1, 1, 4, 1);
      waitResp(50);
      setSlaveDefaults();

      $display("[TB] writeback, bresp error");
      b_resp = 2'b10;
      exp_addr = 32'h8000_0200;
      wq.push_back('{64'hD1, 1'b0});
      wq.push_back('{64'hD2, 1'b1});
      applyStimulus(1, 32'h8000_0200, {64'hD2, 64'hD1}, '0, 1, 0, 5, 1);
      waitResp(50);
      setSlaveDefaults();

      $display("[TB] reset during R");
      r_wait = 5;
      exp_addr = 32'h8000_0300;
      applyStimulus(0, 32'h8000_0300, '0, '0, 0, 0, -1, 0);
      for (int n = 0; n < 20 && !rready; n++) @(negedge clock);
      checkOutput("reached_r", rready, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_rready", rready, 0);
      checkOutput("rst_mid_arvalid", arvalid, 0);
      checkOutput("rst_mid_resp_valid", resp_valid, 0);
      checkOutput("rst_mid_req_ready", req_ready, 1);
      @(negedge clock);
      rst_n = 1'b1;
      setSlaveDefaults();

      $display("[TB] refill after reset");
      hs_before = ar_hs;
      rd_data[0] = 64'h7777; rd_data[1] = 64'h8888;
      exp_addr = 32'h0000_2000;
      applyStimulus(0, 32'h0000_2008, '0, {64'h8888, 64'h7777}, 0, 1, 4, 1);
      waitResp(50);
      checkOutput("fresh_ar", ar_hs, hs_before + 1);

`ifdef CACHE_AXI_MASTER_TIMEOUT_EN
      $display("[TB] watchdog, arready held low");
      ar_wait = 100000;
      exp_addr = 32'h0000_3000;
      applyStimulus(0, 32'h0000_3000, '0, '0, 1, 0, 256, 1);
      waitResp(400);
      setSlaveDefaults();
`endif

      checkOutput("sb_empty", sb.size(), 0);
      checkOutput("wq_empty", wq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/cache_axi_master.md
# cache_axi_master

Cache-side AXI4 burst initiator. Takes one cache-line refill or writeback request at a time from the cache controller and runs it as a single INCR burst on the CPU's master AXI port. In the NPC simulation top it drives the AXI SRAM/LSU memory model.

## Interface
Parameters:
- LINE_BEATS, 2, 64-bit beats per cache line (power of two, 1..16); line width LW = 64*LINE_BEATS
- AXI_ID, 4'd0, constant ID driven on arid/awid

Ports:
- clock  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  cache request valid
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = writeback, 0 = refill
- req_addr  in  32  byte address; low log2(8*LINE_BEATS) bits ignored
- req_wline  in  LW  writeback line, beat 0 in bits [63:0]
- resp_valid  out  1  one-cycle completion pulse
- resp_rline  out  LW  refill line, valid with resp_valid on reads
- resp_err  out  1  error flag, valid with resp_valid
- arvalid/arready/arid[3:0]/araddr[31:0]/arlen[7:0]/arsize[2:0]/arburst[1:0]  AXI read address
- rvalid/rready/rid[3:0]/rdata[63:0]/rresp[1:0]/rlast  AXI read data
- awvalid/awready/awid[3:0]/awaddr[31:0]/awlen[7:0]/awsize[2:0]/awburst[1:0]  AXI write address
- wvalid/wready/wdata[63:0]/wstrb[7:0]/wlast  AXI write data
- bvalid/bready/bid[3:0]/bresp[1:0]  AXI write response

## Operation
- FSM states: IDLE, AR, R, AW, W, B, RESP.
- IDLE:
  - On req_valid && req_ready, latch the aligned address and req_wline.
  - Clear the error flag and beat counter.
  - Go to AW if req_write, else to AR.
- AR: arvalid=1 with address, len, size and burst held stable. On arready, go to R.
- R:
  - rready=1.
  - Each rvalid beat stores rdata into line slot [cnt] and increments cnt.
  - After the beat with cnt==LINE_BEATS-1, go to RESP.
- AW: awvalid=1. On awready, go to W. AW always completes before the first W beat.
- W:
  - wvalid=1, wdata = line slot [cnt].
  - wlast=1 only when cnt==LINE_BEATS-1.
  - On wready, increment cnt. After the last beat, go to B.
- B: bready=1. On bvalid, go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no back-pressure on the response.
- Constant fields:
  - arlen = awlen = LINE_BEATS-1
  - arsize = awsize = 3'b011
  - arburst = awburst = 2'b01 (INCR)
  - wstrb = 8'hFF
  - arid = awid = AXI_ID
- Error flag (sticky per transaction), set by any of:
  - rresp!=0 or bresp!=0
  - rid/bid != AXI_ID
  - rlast asserted on any beat other than the last
  - rlast deasserted on the last beat
- Burst termination follows the beat count only, never rlast.
- On an erroring read, resp_rline still carries whatever data was received.
- The counter is log2(LINE_BEATS)+1 bits and never wraps within a burst.

## Timing
- Reset values:
  - state=IDLE, so req_ready=1 while rst_n is low
  - all AXI valid/ready outputs 0, wlast 0
  - resp_valid 0, resp_err 0, resp_rline 0, cnt 0
- All outputs except req_ready are registered or decoded directly from state.
- Minimum read latency, req handshake to resp_valid: 1 (AR) + LINE_BEATS + 1 cycles, i.e. 4 for LINE_BEATS=2.
- Minimum write latency: 1 (AW) + LINE_BEATS (W) + 1 (B) + 1 cycles, i.e. 5 for LINE_BEATS=2.
- Valids stay asserted with stable payload until their handshake. They never drop without a handshake, except on reset.
- A back-to-back request is accepted no earlier than the cycle after resp_valid.
- rst_n falling mid-burst: immediate return to IDLE with all valids low. No cleanup of the outstanding transaction is attempted.

## Configuration
- CACHE_AXI_MASTER_TIMEOUT_EN defined:
  - An 8-bit watchdog counts cycles in AR/R/AW/W/B without a handshake.
  - When it reaches 255, the FSM goes to RESP with resp_err=1 and all valids drop.
  - This is a debug aid only; it deliberately breaks AXI compliance.
- Not defined: no watchdog logic is present, and a stuck slave hangs the block.

## Test plan
- Refill, addr 0x8000_0018, slave zero-wait, beats 0x1111, 0x2222:
  - araddr=0x8000_0010, arlen=1
  - resp_rline=0x…2222_…1111, resp_err=0
  - resp_valid exactly 4 cycles after the request
- Writeback, addr 0x8000_0040, line {0xBBBB, 0xAAAA}, awready and wready delayed 3 cycles each:
  - AW completes before wvalid
  - wdata order 0xAAAA then 0xBBBB, wlast on beat 2 only
  - resp_err=0
- Refill where the slave returns rresp=2'b10 on beat 0 -> resp_err=1 and both beats still consumed.
- Refill with rlast on beat 0 -> resp_err=1 and the burst still takes 2 beats.
- rst_n pulsed low during the R state -> rready and resp_valid go low at once; the next request issues a fresh AR.
- With CACHE_AXI_MASTER_TIMEOUT_EN, arready held 0 -> resp_valid with resp_err=1 after 255 cycles in AR.
